// File: rtl/fifo_sync.sv
// fifo_sync: single-clock show-ahead FIFO with registered status flags and counts.
// Optional sticky overflow/underflow logic enabled by defining FIFO_SYNC_ERR_EN.
module fifo_sync #(
    parameter int DATA_BITS    = 32,
    parameter int ADDR_BITS    = 8,
    parameter int AFULL_LEVEL  = 2**ADDR_BITS - 4,
    parameter int AEMPTY_LEVEL = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_w,
    input  logic [DATA_BITS-1:0] data_w,
    input  logic                 en_r,
    output logic [DATA_BITS-1:0] data_r,
    output logic                 full_w,
    output logic                 near_full_w,
    output logic                 empty_r,
    output logic                 near_empty_r,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_BITS:0]   data_count,
    output logic [ADDR_BITS:0]   space_count,
    input  logic                 err_clr,
    output logic                 overflow,
    output logic                 underflow
);
    localparam logic [ADDR_BITS:0] DEPTH_C = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [ADDR_BITS:0] AF_C    = (ADDR_BITS+1)'(AFULL_LEVEL);
    localparam logic [ADDR_BITS:0] AE_C    = (ADDR_BITS+1)'(AEMPTY_LEVEL);

    logic [DATA_BITS-1:0] mem [2**ADDR_BITS];
    logic [ADDR_BITS:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic [DATA_BITS-1:0] data_r_q, data_r_d;
    logic full_q, full_d, near_full_q, near_full_d, empty_q, empty_d, near_empty_q, near_empty_d;
    logic afull_q, afull_d, aempty_q, aempty_d;
    logic wr_acc, rd_acc;

    always_comb begin
        wr_acc       = en_w & ~full_q;
        rd_acc       = en_r & ~empty_q;
        wr_ptr_d     = wr_ptr_q + {{ADDR_BITS{1'b0}}, wr_acc};
        rd_ptr_d     = rd_ptr_q + {{ADDR_BITS{1'b0}}, rd_acc};
        count_d      = wr_ptr_d - rd_ptr_d;
        full_d       = count_d == DEPTH_C;
        near_full_d  = count_d == DEPTH_C - 1'b1;
        empty_d      = count_d == '0;
        near_empty_d = count_d == {{ADDR_BITS{1'b0}}, 1'b1};
        afull_d      = count_d >= AF_C;
        aempty_d     = count_d <= AE_C;
        // A head that is being written this edge is not in storage yet, so bypass it.
        data_r_d     = empty_d ? data_r_q :
                       (wr_acc && rd_ptr_d == wr_ptr_q) ? data_w : mem[rd_ptr_d[ADDR_BITS-1:0]];
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !rst)
            mem[wr_ptr_q[ADDR_BITS-1:0]] <= data_w;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            data_r_q     <= '0;
            full_q       <= 1'b0;
            near_full_q  <= 1'b0;
            empty_q      <= 1'b1;
            near_empty_q <= 1'b0;
            afull_q      <= 1'b0;
            aempty_q     <= 1'b1;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            data_r_q     <= data_r_d;
            full_q       <= full_d;
            near_full_q  <= near_full_d;
            empty_q      <= empty_d;
            near_empty_q <= near_empty_d;
            afull_q      <= afull_d;
            aempty_q     <= aempty_d;
        end
    end

    assign data_r       = data_r_q;
    assign full_w       = full_q;
    assign near_full_w  = near_full_q;
    assign empty_r      = empty_q;
    assign near_empty_r = near_empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign data_count   = count_q;
    assign space_count  = DEPTH_C - count_q;

`ifdef FIFO_SYNC_ERR_EN
    logic overflow_q, overflow_d, underflow_q, underflow_d;

    // A new error on the same edge as err_clr keeps the flag set.
    always_comb begin
        overflow_d  = (en_w & full_q) | (overflow_q & ~err_clr);
        underflow_d = (en_r & empty_q) | (underflow_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_sync.sv
// tb_fifo_sync: directed and random checks of fifo_sync against a queue-based model.
module tb_fifo_sync;
    logic       clk = 1'b0, rst = 1'b0, en_w = 1'b0, en_r = 1'b0, err_clr = 1'b0;
    logic [7:0] data_w = '0, data_r;
    logic       full_w, near_full_w, empty_r, near_empty_r, almost_full, almost_empty;
    logic       overflow, underflow;
    logic [2:0] data_count, space_count;
    int         checks = 0, errors = 0;
    logic [7:0] q[$];
    logic       ov = 1'b0, un = 1'b0;

    fifo_sync #(.DATA_BITS(8), .ADDR_BITS(2), .AFULL_LEVEL(3), .AEMPTY_LEVEL(1)) dut (
        .clk(clk), .rst(rst), .en_w(en_w), .data_w(data_w), .en_r(en_r), .data_r(data_r),
        .full_w(full_w), .near_full_w(near_full_w), .empty_r(empty_r), .near_empty_r(near_empty_r),
        .almost_full(almost_full), .almost_empty(almost_empty), .data_count(data_count),
        .space_count(space_count), .err_clr(err_clr), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n = q.size();
        chk("full_w", 8'(full_w), 8'(n == 4));
        chk("near_full_w", 8'(near_full_w), 8'(n == 3));
        chk("empty_r", 8'(empty_r), 8'(n == 0));
        chk("near_empty_r", 8'(near_empty_r), 8'(n == 1));
        chk("almost_full", 8'(almost_full), 8'(n >= 3));
        chk("almost_empty", 8'(almost_empty), 8'(n <= 1));
        chk("data_count", 8'(data_count), 8'(n));
        chk("space_count", 8'(space_count), 8'(4 - n));
        chk("overflow", 8'(overflow), 8'(ov));
        chk("underflow", 8'(underflow), 8'(un));
        if (n > 0) chk("data_r", data_r, q[0]);
    endtask

    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c, input logic rs);
        logic was_full, was_empty;
        en_w = w; data_w = d; en_r = r; err_clr = c; rst = rs;
        @(posedge clk);
        was_full  = q.size() == 4;
        was_empty = q.size() == 0;
        if (rs) begin
            q.delete();
            ov = 1'b0;
            un = 1'b0;
        end else begin
`ifdef FIFO_SYNC_ERR_EN
            ov = (w && was_full) ? 1'b1 : c ? 1'b0 : ov;
            un = (r && was_empty) ? 1'b1 : c ? 1'b0 : un;
`endif
            if (r && !was_empty) void'(q.pop_front());
            if (w && !was_full) q.push_back(d);
        end
        #1;
        check_all();
        en_w = 1'b0; en_r = 1'b0; err_clr = 1'b0; rst = 1'b0;
    endtask

    initial begin
        step(0, 8'h00, 0, 0, 1);
        chk("data_r_reset", data_r, 8'h00);
        step(1, 8'hA5, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        for (int i = 1; i <= 5; i++) step(1, 8'(i), 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 8'(8'h11 + i), 0, 0, 0);
        step(1, 8'h99, 1, 0, 0);
        chk("no_99_head", 8'(data_r == 8'h99), 8'h00);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 0);
        step(1, 8'h10, 0, 0, 0);
        step(1, 8'h20, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(1, 8'h30, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 1, 0);
        step(0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 8'(8'h40 + i), 0, 0, 0);
        step(1, 8'h77, 1, 0, 1);
        chk("data_r_reset2", data_r, 8'h00);
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 49) == 0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
